// File: rtl/debounce_edge.sv
// debounce_edge: debounces a raw level into a clean registered level with rise/fall strobes.
//   clk   - clock, all state updates on posedge
//   rst_n - asynchronous active-low reset
//   d     - raw, possibly bouncing level
//   out   - debounced level
//   rise  - one-cycle strobe in the cycle out goes 0->1
//   fall  - one-cycle strobe in the cycle out goes 1->0
//   busy  - high while a transition is being qualified or held off
// Optional: define DEBOUNCE_SYNC2_EN to add a 2-flop synchronizer ahead of the sample register.
module debounce_edge #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned HOLDOFF_CYCLES = 2,
    parameter logic        RST_VAL        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLDOFF_CYCLES - 1);
    logic   d_in, d_q;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic   out_q, out_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;
`ifdef DEBOUNCE_SYNC2_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{RST_VAL}};
        else        sync_q <= {sync_q[0], d};
    end
    assign d_in = sync_q[1];
`else
    assign d_in = d;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= RST_VAL;
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            out_q   <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            d_q     <= d_in;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_q != out_q) begin
                    state_d = WAIT;
                    cnt_d   = 8'd1;
                end
            end
            WAIT: begin
                if (d_q == out_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == STABLE_LAST) begin
                    out_d   = d_q;
                    rise_d  = d_q;
                    fall_d  = !d_q;
                    cnt_d   = 8'd0;
                    state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // registered so busy lines up with the cycles the FSM sits in WAIT/HOLD
        busy_d = (state_d == WAIT) || (state_d == HOLD);
    end
    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: directed checks plus a run-length reference model for debounce_edge.
module tb_debounce_edge;
    localparam int S = 4;
    localparam int H = 2;
`ifdef DEBOUNCE_SYNC2_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif
    localparam int DEPTH = 1 + SX;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d = 1'b0;
    logic out, rise, fall, busy;
    int n_chk = 0, n_fail = 0, n_rise = 0, n_fall = 0;

    // Reference: out follows once S consecutive evaluated samples differ from it;
    // for H edges after each accepted transition samples are ignored.
    logic m_out, m_rise, m_fall;
    int   m_run, m_hold;
    logic m_pipe [DEPTH];
    wire  m_busy = (m_hold > 0) || (m_run > 0);

    debounce_edge #(.STABLE_CYCLES(S), .HOLDOFF_CYCLES(H), .RST_VAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .out(out), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin : model
        logic s;
        if (!rst_n) begin
            m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_hold = 0;
            for (int i = 0; i < DEPTH; i++) m_pipe[i] = 1'b0;
        end else begin
            s = m_pipe[DEPTH-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_hold > 0) begin
                m_hold = m_hold - 1;
            end else if (s != m_out) begin
                m_run = m_run + 1;
                if (m_run == S) begin
                    m_out = s; m_rise = s; m_fall = !s; m_run = 0; m_hold = H;
                end
            end else begin
                m_run = 0;
            end
            for (int i = DEPTH - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = d;
        end
    end

    task automatic chk(input string nm, input logic a, input logic e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                n_rise += int'(rise);
                n_fall += int'(fall);
                chk("model out", out, m_out);
                chk("model rise", rise, m_rise);
                chk("model fall", fall, m_fall);
                chk("model busy", busy, m_busy);
            end
            begin
                rst_n = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    d = ~d;
                    tick(1);
                    chk("reset out", out, 1'b0);
                    chk("reset busy", busy, 1'b0);
                    chk("reset rise", rise, 1'b0);
                end
                d = 1'b0;
                rst_n = 1'b1;
                tick(3);
                chk("release out", out, 1'b0);
                chki("release strobes", n_rise + n_fall, 0);

                // clean rise, then holdoff glitch
                d = 1'b1;
                tick(1 + SX);
                chk("rise busy k", busy, 1'b0);
                tick(1);
                chk("rise busy k+1", busy, 1'b1);
                chk("rise out k+1", out, 1'b0);
                tick(2);
                chk("rise out k+3", out, 1'b0);
                chk("rise rise k+3", rise, 1'b0);
                tick(1);
                chk("rise out k+4", out, 1'b1);
                chk("rise rise k+4", rise, 1'b1);
                d = 1'b0;
                tick(1);
                chk("rise rise k+5", rise, 1'b0);
                chk("rise busy k+5", busy, 1'b1);
                tick(1);
                chk("rise busy k+6", busy, 1'b0);
                d = 1'b1;
                tick(10);
                chk("holdoff out", out, 1'b1);
                chki("holdoff falls", n_fall, 0);
                chki("holdoff rises", n_rise, 1);

                // fall
                d = 1'b0;
                tick(SX + 4);
                chk("fall out c+3", out, 1'b1);
                chk("fall fall c+3", fall, 1'b0);
                tick(1);
                chk("fall out c+4", out, 1'b0);
                chk("fall fall c+4", fall, 1'b1);
                tick(1);
                chk("fall fall c+5", fall, 1'b0);
                tick(6);
                chki("fall count", n_fall, 1);
                chki("fall rises", n_rise, 1);

                // bounce 1,1,0 then stable 1
                d = 1'b1;
                tick(2);
                d = 1'b0;
                tick(1);
                d = 1'b1;
                tick(1 + SX + 3);
                chk("bounce out b+3", out, 1'b0);
                chki("bounce no pulse", n_rise, 1);
                tick(1);
                chk("bounce out b+4", out, 1'b1);
                chk("bounce rise b+4", rise, 1'b1);
                tick(6);
                chki("bounce one rise", n_rise, 2);

                // async reset in the middle of WAIT
                d = 1'b0;
                tick(12);
                chk("pre-reset out", out, 1'b0);
                chki("pre-reset falls", n_fall, 2);
                d = 1'b1;
                tick(3 + SX);
                chk("mid-wait busy", busy, 1'b1);
                #2 rst_n = 1'b0;
                #1;
                chk("async out", out, 1'b0);
                chk("async busy", busy, 1'b0);
                chk("async rise", rise, 1'b0);
                tick(2);
                rst_n = 1'b1;
                tick(1 + SX + 3);
                chk("post-reset out e+3", out, 1'b0);
                chki("post-reset no rise", n_rise, 2);
                tick(1);
                chk("post-reset out e+4", out, 1'b1);
                chk("post-reset rise e+4", rise, 1'b1);
                tick(4);
                chki("total rises", n_rise, 3);
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
